// File: rtl/mux_rr_sched_pkg.sv
// rtl/mux_rr_sched_pkg.sv - shared types for the round-robin scheduler
package mux_sched_pkg;

   localparam int NCH = 4;

   typedef logic [1:0] ch_idx_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/mux_rr_sched_if.sv
// rtl/mux_rr_sched_if.sv - four-channel request side plus registered output side
interface mux_rr_sched_if
   import mux_sched_pkg::*;
#(
   parameter int WIDTH = 4
);

   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] a2;
   logic [WIDTH-1:0] a3;
   logic [WIDTH-1:0] a4;
   logic [NCH-1:0]   a_valid;
   logic [NCH-1:0]   a_ready;
   ch_idx_t          s;
   logic [WIDTH-1:0] d;
   logic             d_valid;
   logic             d_ready;

   // Environment side: drives channel words and downstream ready
   modport master (
      output a1, a2, a3, a4, a_valid, d_ready,
      input  a_ready, s, d, d_valid
   );

   // Scheduler side
   modport slave (
      input  a1, a2, a3, a4, a_valid, d_ready,
      output a_ready, s, d, d_valid
   );

endinterface

// File: rtl/mux_rr_sched_rr_pick4.sv
// rtl/mux_rr_sched_rr_pick4.sv - combinational rotate-priority picker
module rr_pick4
   import mux_sched_pkg::*;
(
   input  logic [NCH-1:0] req,
   input  ch_idx_t        last,
   input  logic           stay,
   output logic [NCH-1:0] gnt,
   output ch_idx_t        idx,
   output logic           any
);

   ch_idx_t cand;
   logic    found;

   // Keep the current channel if allowed, else search last+1 .. last+4 (last itself comes last)
   always_comb begin
      gnt   = '0;
      idx   = last;
      any   = |req;
      found = 1'b0;
      cand  = last;
      if (stay && req[last]) begin
         found = 1'b1;
      end
      for (int k = 1; k <= NCH; k++) begin
         cand = last + ch_idx_t'(k);
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
      if (found) begin
         gnt[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/mux_rr_sched.sv
// rtl/mux_rr_sched.sv - round-robin scheduler feeding mux_4x1 with registered word and select
module mux_rr_sched
   import mux_sched_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int BURST = 2,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mux_rr_sched_if.slave          bus,
   output logic [NCH*CNT_W-1:0]   grant_cnt
);

   localparam int             BW      = $clog2(BURST + 1);
   localparam logic [BW-1:0]  BURST_V = BW'(BURST);

   state_t                     state;
   state_t                     state_nxt;
   logic [WIDTH-1:0]           d_q;
   ch_idx_t                    s_q;
   ch_idx_t                    last;
   ch_idx_t                    idx;
   logic [BW-1:0]              burst_cnt;
   logic [NCH-1:0][CNT_W-1:0]  cnt;
   logic [NCH-1:0]             gnt;
   logic [WIDTH-1:0]           win_data;
   logic                       any;
   logic                       load;
   logic                       xfer;
   logic                       stay;

   // burst_cnt is zero only straight out of reset: no burst is in progress then,
   // so the reset value of last must not be allowed to claim the first beat.
   assign stay = (burst_cnt != '0) && (burst_cnt < BURST_V);

   rr_pick4 u_pick (
      .req  (bus.a_valid),
      .last (last),
      .stay (stay),
      .gnt  (gnt),
      .idx  (idx),
      .any  (any)
   );

   // Winning channel word
   always_comb begin
      win_data = bus.a1;
      case (idx)
         2'd0:    win_data = bus.a1;
         2'd1:    win_data = bus.a2;
         2'd2:    win_data = bus.a3;
         default: win_data = bus.a4;
      endcase
   end

   // FSM next state, load/transfer decode, ready and valid outputs
   always_comb begin
      state_nxt   = state;
      load        = (state == EMPTY) | bus.d_ready;
      xfer        = load & any & rst_n;
      bus.a_ready = xfer ? gnt : '0;
      bus.d_valid = (state == FULL);
      case (state)
         EMPTY: if (xfer) state_nxt = FULL;
         FULL:  if (bus.d_ready) state_nxt = xfer ? FULL : EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Output register, rotation pointer, burst and saturating grant counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q       <= '0;
         s_q       <= '0;
         last      <= 2'd3;
         burst_cnt <= '0;
         cnt       <= '0;
      end else if (xfer) begin
         d_q  <= win_data;
         s_q  <= idx;
         last <= idx;
         if (idx == last) begin
            if (burst_cnt != BURST_V) burst_cnt <= burst_cnt + 1'b1;
         end else begin
            burst_cnt <= BW'(1);
         end
         if (cnt[idx] != '1) cnt[idx] <= cnt[idx] + 1'b1;
      end
   end

   assign bus.d     = d_q;
   assign bus.s     = s_q;
   assign grant_cnt = cnt;

endmodule

// File: tb/tb_mux_rr_sched.sv
// tb/tb_mux_rr_sched.sv - directed vector bench for mux_rr_sched
module tb_mux_rr_sched;
   import mux_sched_pkg::*;

   localparam int W  = 4;
   localparam int CW = 8;
   localparam int NV = 21;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux_rr_sched_if #(.WIDTH(W)) bus0 ();
   mux_rr_sched_if #(.WIDTH(W)) bus1 ();
   logic [4*CW-1:0] gc0;
   logic [4*CW-1:0] gc1;

   mux_rr_sched #(.WIDTH(W), .BURST(2), .CNT_W(CW)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .grant_cnt(gc0));
   mux_rr_sched #(.WIDTH(W), .BURST(1), .CNT_W(CW)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .grant_cnt(gc1));

   typedef struct {
      logic [3:0] av;
      logic       dr;
      logic [3:0] rdy;
      logic       dv;
      logic [1:0] s;
      logic [3:0] d;
   } vec_t;

   vec_t tbl [NV];
   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic             hold_prev = 1'b0;
   logic [W-1:0]     d_prev;
   ch_idx_t          s_prev;

   always @(negedge clk) begin
      chk("onehot0_dut0", 32'($onehot0(bus0.a_ready)), 32'd1);
      chk("onehot0_dut1", 32'($onehot0(bus1.a_ready)), 32'd1);
      if (hold_prev && rst_n) begin
         chk("hold_d", 32'(bus0.d), 32'(d_prev));
         chk("hold_s", 32'(bus0.s), 32'(s_prev));
         chk("hold_dv", 32'(bus0.d_valid), 32'd1);
      end
      hold_prev = rst_n && bus0.d_valid && !bus0.d_ready;
      d_prev    = bus0.d;
      s_prev    = bus0.s;
   end

   initial begin
      //             av       dr    rdy      dv    s     d
      tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 4'd5};
      tbl[1]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1};
      tbl[2]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1};
      tbl[3]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd6};
      tbl[4]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd6};
      tbl[5]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1};
      tbl[6]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1};
      tbl[7]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd6};
      tbl[8]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd6};
      tbl[9]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd6};
      tbl[10] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd6};
      tbl[11] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd6};
      tbl[12] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1};
      tbl[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd6};
      tbl[14] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd6};
      tbl[15] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1};
      tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0};
      tbl[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'd0};
      tbl[18] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 4'd4};
      tbl[19] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd1};
      tbl[20] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0};

      bus0.a1 = 4'd1; bus0.a2 = 4'd6; bus0.a3 = 4'd5; bus0.a4 = 4'd4;
      bus1.a1 = 4'd1; bus1.a2 = 4'd2; bus1.a3 = 4'd3; bus1.a4 = 4'd4;
      bus0.a_valid = 4'b1111; bus0.d_ready = 1'b1;
      bus1.a_valid = 4'b1111; bus1.d_ready = 1'b1;

      // Reset state, with every channel requesting
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a_ready0", 32'(bus0.a_ready), 32'd0);
      chk("rst_a_ready1", 32'(bus1.a_ready), 32'd0);
      chk("rst_d_valid", 32'(bus0.d_valid), 32'd0);
      chk("rst_s", 32'(bus0.s), 32'd0);
      chk("rst_d", 32'(bus0.d), 32'd0);
      chk("rst_gcnt", gc0, 32'd0);
      bus0.a_valid = 4'b0000;
      bus1.a_valid = 4'b0000;
      rst_n = 1'b1;

      // Table: single requester, BURST=2 alternation, stall hold, drop, empty, wrap
      for (int i = 0; i < NV; i++) begin
         bus0.a_valid = tbl[i].av;
         bus0.d_ready = tbl[i].dr;
         #1;
         chk($sformatf("v%0d_a_ready", i), 32'(bus0.a_ready), 32'(tbl[i].rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_d_valid", i), 32'(bus0.d_valid), 32'(tbl[i].dv));
         if (tbl[i].dv) begin
            chk($sformatf("v%0d_s", i), 32'(bus0.s), 32'(tbl[i].s));
            chk($sformatf("v%0d_d", i), 32'(bus0.d), 32'(tbl[i].d));
         end
      end
      chk("gcnt0", 32'(gc0[0*CW +: CW]), 32'd7);
      chk("gcnt1", 32'(gc0[1*CW +: CW]), 32'd6);
      chk("gcnt2", 32'(gc0[2*CW +: CW]), 32'd1);
      chk("gcnt3", 32'(gc0[3*CW +: CW]), 32'd1);

      // Sole requester ch3: counter climbs to all-ones and stays there
      bus0.a_valid = 4'b1000;
      bus0.d_ready = 1'b1;
      repeat (253) @(posedge clk);
      #1;
      chk("gcnt3_254", 32'(gc0[3*CW +: CW]), 32'd254);
      repeat (8) @(posedge clk);
      #1;
      chk("gcnt3_sat", 32'(gc0[3*CW +: CW]), 32'd255);
      chk("sole_s", 32'(bus0.s), 32'd3);

      // BURST=1 with all four requesting: strict rotation from reset
      for (int k = 0; k < 5; k++) begin
         logic [3:0] one;
         one = 4'b0001 << (k % 4);
         bus1.a_valid = 4'b1111;
         #1;
         chk($sformatf("rot%0d_a_ready", k), 32'(bus1.a_ready), 32'(one));
         @(posedge clk);
         #1;
         chk($sformatf("rot%0d_s", k), 32'(bus1.s), 32'(k % 4));
      end
      bus1.a_valid = 4'b0000;
      chk("rot_gcnt0", 32'(gc1[0*CW +: CW]), 32'd2);
      chk("rot_gcnt3", 32'(gc1[3*CW +: CW]), 32'd1);
      chk("gcnt3_nowrap", 32'(gc0[3*CW +: CW]), 32'd255);

      // Async reset mid-burst while FULL
      bus0.a_valid = 4'b0010;
      #1;
      chk("pre_rst_a_ready", 32'(bus0.a_ready), 32'b0010);
      @(posedge clk);
      #1;
      chk("pre_rst_s", 32'(bus0.s), 32'd1);
      chk("pre_rst_d", 32'(bus0.d), 32'd6);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_d_valid", 32'(bus0.d_valid), 32'd0);
      chk("arst_s", 32'(bus0.s), 32'd0);
      chk("arst_d", 32'(bus0.d), 32'd0);
      chk("arst_a_ready", 32'(bus0.a_ready), 32'd0);
      chk("arst_gcnt", gc0, 32'd0);
      bus0.a_valid = 4'b1111;
      @(posedge clk);
      #1;
      chk("arst_hold_a_ready", 32'(bus0.a_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_a_ready", 32'(bus0.a_ready), 32'b0001);
      @(posedge clk);
      #1;
      chk("post_rst_s", 32'(bus0.s), 32'd0);
      chk("post_rst_d", 32'(bus0.d), 32'd1);
      chk("post_rst_dv", 32'(bus0.d_valid), 32'd1);

      bus0.a_valid = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
